// File: rtl/usbf_dma_eng_if.sv
// WISHBONE master bus bundle used by the USB function DMA engine.
// The master modport is the engine side; the slave modport is the memory/bus side.
interface usbf_dma_eng_if;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dout;
  logic [31:0] wbm_din;
  logic        wbm_we;
  logic        wbm_stb;
  logic [3:0]  wbm_sel;
  logic        wbm_ack;
  logic        wbm_err;

  modport master (
    output wbm_adr, wbm_dout, wbm_we, wbm_stb, wbm_sel,
    input  wbm_din, wbm_ack, wbm_err
  );

  modport slave (
    input  wbm_adr, wbm_dout, wbm_we, wbm_stb, wbm_sel,
    output wbm_din, wbm_ack, wbm_err
  );
endinterface

// File: rtl/usbf_dma_eng.sv
// Single-channel DMA engine: one 32-bit word per endpoint dma_req, moved by a
// WISHBONE read followed by a write, with the buffer side wrapping inside a ring.
module usbf_dma_eng #(
  parameter int LEN_W = 16,
  parameter int OFF_W = 12
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_dir,
  input  logic [31:0]      cfg_mem_adr,
  input  logic [31:0]      cfg_buf_base,
  input  logic [OFF_W-1:0] cfg_buf_sz,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             ch_en,
  input  logic             dma_req,
  output logic             dma_ack,
  usbf_dma_eng_if.master   wb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] rem
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]       state_q,   state_d;
  logic [29:0]      mem_ptr_q, mem_ptr_d;
  logic [29:0]      base_q,    base_d;
  logic [OFF_W-1:0] buf_off_q, buf_off_d;
  logic [OFF_W-1:0] sz_q,      sz_d;
  logic [LEN_W-1:0] rem_q,     rem_d;
  logic [31:0]      data_r_q,  data_r_d;
  logic             dir_q,     dir_d;
  logic             err_q,     err_d;

  logic             load_cfg;
  logic [29:0]      buf_word;
  logic [29:0]      adr_word;
  logic             unused_cfg_bits;

  assign unused_cfg_bits = ^{cfg_mem_adr[1:0], cfg_buf_base[1:0]};

  assign load_cfg = cfg_we && ((state_q == S_IDLE) || (state_q == S_ERR));
  assign buf_word = base_q + 30'(buf_off_q);

  always_comb begin
    state_d   = state_q;
    mem_ptr_d = mem_ptr_q;
    base_d    = base_q;
    buf_off_d = buf_off_q;
    sz_d      = sz_q;
    rem_d     = rem_q;
    data_r_d  = data_r_q;
    dir_d     = dir_q;
    err_d     = err_q;

    if (load_cfg) begin
      mem_ptr_d = cfg_mem_adr[31:2];
      base_d    = cfg_buf_base[31:2];
      buf_off_d = '0;
      sz_d      = cfg_buf_sz;
      rem_d     = cfg_len;
      dir_d     = cfg_dir;
      err_d     = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!load_cfg && ch_en && dma_req && (rem_q != '0) && !err_q)
          state_d = S_RD;
      end
      S_RD: begin
        if (wb.wbm_err) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (!ch_en) begin
          state_d = S_IDLE;
        end else if (wb.wbm_ack) begin
          data_r_d = wb.wbm_din;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        if (wb.wbm_err) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (!ch_en) begin
          state_d = S_IDLE;
        end else if (wb.wbm_ack) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // A ring size of 0 makes sz-1 all ones, giving the full 2^OFF_W ring.
        rem_d     = rem_q - LEN_W'(1);
        mem_ptr_d = mem_ptr_q + 30'd1;
        buf_off_d = (buf_off_q == (sz_q - OFF_W'(1))) ? '0 : (buf_off_q + OFF_W'(1));
        state_d   = S_IDLE;
      end
      S_ERR: begin
        if (load_cfg)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mem_ptr_q <= '0;
      base_q    <= '0;
      buf_off_q <= '0;
      sz_q      <= '0;
      rem_q     <= '0;
      data_r_q  <= '0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_ptr_q <= mem_ptr_d;
      base_q    <= base_d;
      buf_off_q <= buf_off_d;
      sz_q      <= sz_d;
      rem_q     <= rem_d;
      data_r_q  <= data_r_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  // Read from the source side, write to the destination side; idle bus shows 0.
  always_comb begin
    adr_word = '0;
    case (state_q)
      S_RD:    adr_word = dir_q ? mem_ptr_q : buf_word;
      S_WR:    adr_word = dir_q ? buf_word : mem_ptr_q;
      default: adr_word = '0;
    endcase
  end

  assign wb.wbm_adr  = {adr_word, 2'b00};
  assign wb.wbm_dout = data_r_q;
  assign wb.wbm_stb  = (state_q == S_RD) || (state_q == S_WR);
  assign wb.wbm_we   = (state_q == S_WR);
  assign wb.wbm_sel  = 4'hf;

  assign dma_ack = (state_q == S_ACK);
  assign done    = (state_q == S_ACK) && (rem_q == LEN_W'(1));
  assign busy    = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_ACK);
  assign err     = err_q;
  assign rem     = rem_q;

endmodule

// File: tb/tb_usbf_dma_eng.sv
// Directed bench for usbf_dma_eng with a WISHBONE slave model whose read data
// is a fixed function of the address and whose wait states are programmable.
module tb_usbf_dma_eng;
  localparam int LEN_W = 16;
  localparam int OFF_W = 12;

  logic             wclk;
  logic             rst;
  logic             cfg_we;
  logic             cfg_dir;
  logic [31:0]      cfg_mem_adr;
  logic [31:0]      cfg_buf_base;
  logic [OFF_W-1:0] cfg_buf_sz;
  logic [LEN_W-1:0] cfg_len;
  logic             ch_en;
  logic             dma_req;
  logic             dma_ack;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] rem;

  usbf_dma_eng_if wb();

  usbf_dma_eng #(.LEN_W(LEN_W), .OFF_W(OFF_W)) dut (
    .wclk         (wclk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_dir      (cfg_dir),
    .cfg_mem_adr  (cfg_mem_adr),
    .cfg_buf_base (cfg_buf_base),
    .cfg_buf_sz   (cfg_buf_sz),
    .cfg_len      (cfg_len),
    .ch_en        (ch_en),
    .dma_req      (dma_req),
    .dma_ack      (dma_ack),
    .wb           (wb),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rem          (rem)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Slave model: ack after 'waits' extra cycles, optional error on one address.
  int          waits;
  int          wait_cnt;
  logic        inject_err;
  logic [31:0] err_adr;

  assign wb.wbm_ack = wb.wbm_stb && (wait_cnt == waits);
  assign wb.wbm_err = wb.wbm_stb && wb.wbm_we && inject_err && (wb.wbm_adr == err_adr);
  assign wb.wbm_din = wb.wbm_stb ? memData(wb.wbm_adr) : 32'h0;

  always @(posedge wclk) begin
    if (!wb.wbm_stb || wb.wbm_ack) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end

  // Monitor: completed bus transfers, ack/done cycles, strobe-phase stability.
  int          cycle;
  logic [31:0] bus_adr_q[$];
  logic [31:0] bus_dat_q[$];
  logic        bus_we_q[$];
  int          ack_cyc_q[$];
  int          done_cnt;
  int          done_cyc;
  int          unstable;
  logic        prev_stb, prev_ack, prev_we;
  logic [31:0] prev_adr, prev_dout;

  initial begin
    cycle = 0; done_cnt = 0; done_cyc = 0; unstable = 0;
    prev_stb = 0; prev_ack = 0; prev_we = 0; prev_adr = 0; prev_dout = 0;
  end

  always @(negedge wclk) begin
    cycle = cycle + 1;
    if (wb.wbm_stb && wb.wbm_ack && !wb.wbm_err) begin
      bus_adr_q.push_back(wb.wbm_adr);
      bus_dat_q.push_back(wb.wbm_we ? wb.wbm_dout : wb.wbm_din);
      bus_we_q.push_back(wb.wbm_we);
    end
    if (dma_ack) ack_cyc_q.push_back(cycle);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cycle;
    end
    if (wb.wbm_stb && prev_stb && !prev_ack &&
        (wb.wbm_adr != prev_adr || wb.wbm_dout != prev_dout || wb.wbm_we != prev_we))
      unstable = unstable + 1;
    prev_stb  = wb.wbm_stb;
    prev_ack  = wb.wbm_ack;
    prev_we   = wb.wbm_we;
    prev_adr  = wb.wbm_adr;
    prev_dout = wb.wbm_dout;
  end

  int checks;
  int passed;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    else
      passed++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic applyStimulus(input logic dir, input logic [31:0] mem_a, input logic [31:0] base_a,
                               input logic [OFF_W-1:0] sz, input logic [LEN_W-1:0] len);
    cfg_dir      = dir;
    cfg_mem_adr  = mem_a;
    cfg_buf_base = base_a;
    cfg_buf_sz   = sz;
    cfg_len      = len;
    cfg_we       = 1'b1;
    tick(1);
    cfg_we       = 1'b0;
  endtask

  task automatic clearLogs();
    bus_adr_q.delete();
    bus_dat_q.delete();
    bus_we_q.delete();
    ack_cyc_q.delete();
    done_cnt = 0;
  endtask

  int start;
  logic [31:0] a;

  initial begin
    checks = 0; passed = 0;
    rst = 1'b0; cfg_we = 0; cfg_dir = 0; cfg_mem_adr = 0; cfg_buf_base = 0;
    cfg_buf_sz = 0; cfg_len = 0; ch_en = 0; dma_req = 0;
    waits = 0; inject_err = 0; err_adr = 0;
    tick(3);
    rst = 1'b1;
    tick(1);
    checkOutput("init_stb",  32'(wb.wbm_stb), 32'd0);
    checkOutput("init_busy", 32'(busy), 32'd0);
    checkOutput("init_rem",  32'(rem), 32'd0);
    checkOutput("init_adr",  wb.wbm_adr, 32'd0);
    checkOutput("init_sel",  32'(wb.wbm_sel), 32'hf);

    $display("[TB] IN transfer, 3 words, zero-wait slave");
    ch_en = 1'b1;
    applyStimulus(1'b1, 32'h1000, 32'h8000, 12'd8, 16'd3);
    clearLogs();
    start = cycle;
    dma_req = 1'b1;
    tick(25);
    checkOutput("in_acks",    32'(ack_cyc_q.size()), 32'd3);
    checkOutput("in_latency", 32'(ack_cyc_q[0] - start), 32'd4);
    checkOutput("in_gap1",    32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd4);
    checkOutput("in_gap2",    32'(ack_cyc_q[2] - ack_cyc_q[1]), 32'd4);
    checkOutput("in_done_n",  32'(done_cnt), 32'd1);
    checkOutput("in_done_at", 32'(done_cyc), 32'(ack_cyc_q[2]));
    checkOutput("in_rem",     32'(rem), 32'd0);
    checkOutput("in_xfers",   32'(bus_adr_q.size()), 32'd6);
    for (int i = 0; i < 3; i++) begin
      a = 32'h1000 + 32'(4 * i);
      checkOutput("in_rd_adr", bus_adr_q[2*i], a);
      checkOutput("in_rd_we",  32'(bus_we_q[2*i]), 32'd0);
      checkOutput("in_wr_adr", bus_adr_q[2*i+1], 32'h8000 + 32'(4 * i));
      checkOutput("in_wr_dat", bus_dat_q[2*i+1], memData(a));
      checkOutput("in_wr_we",  32'(bus_we_q[2*i+1]), 32'd1);
    end

    $display("[TB] OUT transfer with ring of 2 words");
    dma_req = 1'b0;
    applyStimulus(1'b0, 32'h2000, 32'h8000, 12'd2, 16'd3);
    clearLogs();
    dma_req = 1'b1;
    tick(25);
    checkOutput("out_acks",  32'(ack_cyc_q.size()), 32'd3);
    checkOutput("out_xfers", 32'(bus_adr_q.size()), 32'd6);
    for (int i = 0; i < 3; i++) begin
      a = 32'h8000 + 32'(4 * (i % 2));
      checkOutput("out_rd_adr", bus_adr_q[2*i], a);
      checkOutput("out_wr_adr", bus_adr_q[2*i+1], 32'h2000 + 32'(4 * i));
      checkOutput("out_wr_dat", bus_dat_q[2*i+1], memData(a));
    end

    $display("[TB] Two wait states per access");
    dma_req = 1'b0;
    waits = 2;
    applyStimulus(1'b1, 32'h3000, 32'h9000, 12'd0, 16'd2);
    clearLogs();
    unstable = 0;
    start = cycle;
    dma_req = 1'b1;
    tick(30);
    checkOutput("ws_acks",    32'(ack_cyc_q.size()), 32'd2);
    checkOutput("ws_latency", 32'(ack_cyc_q[0] - start), 32'd8);
    checkOutput("ws_gap",     32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd8);
    checkOutput("ws_stable",  32'(unstable), 32'd0);
    checkOutput("ws_wr_adr1", bus_adr_q[3], 32'h9004);
    checkOutput("ws_wr_dat1", bus_dat_q[3], memData(32'h3004));

    $display("[TB] Bus error on second word write");
    dma_req = 1'b0;
    waits = 0;
    err_adr = 32'hA004;
    inject_err = 1'b1;
    applyStimulus(1'b1, 32'h4000, 32'hA000, 12'd8, 16'd4);
    clearLogs();
    dma_req = 1'b1;
    tick(20);
    checkOutput("err_acks",  32'(ack_cyc_q.size()), 32'd1);
    checkOutput("err_flag",  32'(err), 32'd1);
    checkOutput("err_rem",   32'(rem), 32'd3);
    checkOutput("err_stb",   32'(wb.wbm_stb), 32'd0);
    checkOutput("err_busy",  32'(busy), 32'd0);
    checkOutput("err_done",  32'(done_cnt), 32'd0);
    dma_req = 1'b0;
    inject_err = 1'b0;
    applyStimulus(1'b1, 32'h4000, 32'hA000, 12'd8, 16'd5);
    checkOutput("err_clear", 32'(err), 32'd0);
    checkOutput("err_rem2",  32'(rem), 32'd5);

    $display("[TB] Channel disable during read");
    waits = 3;
    applyStimulus(1'b1, 32'h5000, 32'hB000, 12'd8, 16'd1);
    clearLogs();
    dma_req = 1'b1;
    tick(1);
    checkOutput("ab_in_rd",  32'(wb.wbm_stb), 32'd1);
    ch_en = 1'b0;
    tick(1);
    checkOutput("ab_stb",    32'(wb.wbm_stb), 32'd0);
    checkOutput("ab_busy",   32'(busy), 32'd0);
    tick(5);
    checkOutput("ab_noack",  32'(ack_cyc_q.size()), 32'd0);
    checkOutput("ab_rem",    32'(rem), 32'd1);
    ch_en = 1'b1;
    tick(30);
    checkOutput("ab_acks",   32'(ack_cyc_q.size()), 32'd1);
    checkOutput("ab_rd_adr", bus_adr_q[0], 32'h5000);
    checkOutput("ab_wr_adr", bus_adr_q[1], 32'hB000);
    checkOutput("ab_rem0",   32'(rem), 32'd0);

    $display("[TB] Reset during read");
    dma_req = 1'b0;
    applyStimulus(1'b1, 32'h6000, 32'hC000, 12'd8, 16'd2);
    clearLogs();
    dma_req = 1'b1;
    tick(1);
    checkOutput("rs_in_rd", 32'(wb.wbm_stb), 32'd1);
    rst = 1'b0;
    tick(1);
    checkOutput("rs_stb_next", 32'(wb.wbm_stb), 32'd0);
    tick(1);
    checkOutput("rs_we",   32'(wb.wbm_we), 32'd0);
    checkOutput("rs_adr",  wb.wbm_adr, 32'd0);
    checkOutput("rs_dout", wb.wbm_dout, 32'd0);
    checkOutput("rs_ack",  32'(dma_ack), 32'd0);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    checkOutput("rs_done", 32'(done), 32'd0);
    checkOutput("rs_err",  32'(err), 32'd0);
    checkOutput("rs_rem",  32'(rem), 32'd0);
    rst = 1'b1;
    tick(10);
    checkOutput("rs_noack", 32'(ack_cyc_q.size()), 32'd0);

    $display("[TB] Zero-length configuration");
    dma_req = 1'b0;
    waits = 0;
    applyStimulus(1'b1, 32'h7000, 32'hD000, 12'd8, 16'd0);
    clearLogs();
    dma_req = 1'b1;
    tick(20);
    checkOutput("zl_acks",  32'(ack_cyc_q.size()), 32'd0);
    checkOutput("zl_xfers", 32'(bus_adr_q.size()), 32'd0);
    checkOutput("zl_busy",  32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/usbf_dma_eng.md
# usbf_dma_eng

Single-channel DMA engine that answers an endpoint's DMA request/acknowledge handshake. For every `dma_req` it moves one 32-bit word over a WISHBONE master port: system memory to the endpoint buffer for IN endpoints, or endpoint buffer to system memory for OUT endpoints. Each completed word is reported with a one-cycle `dma_ack`. It sits on the WISHBONE clock side, beside the endpoint register file whose request it services, and its buffer pointer wraps inside a ring matching the endpoint buffer.

## Interface
- `LEN_W`, 16, width of the word-count register
- `OFF_W`, 12, width of the buffer word offset / ring size
- `wclk`  in  1  WISHBONE-side clock; the only clock
- `rst`  in  1  reset, synchronous, active-low
- `cfg_we`  in  1  load the configuration below; clears `err`; accepted only in IDLE or ERR
- `cfg_dir`  in  1  1 = IN (memory->buffer), 0 = OUT (buffer->memory)
- `cfg_mem_adr`  in  32  system memory start byte address; bits [1:0] ignored
- `cfg_buf_base`  in  32  buffer base byte address; bits [1:0] ignored
- `cfg_buf_sz`  in  OFF_W  ring size in words; 0 means 2^OFF_W
- `cfg_len`  in  LEN_W  number of words to transfer
- `ch_en`  in  1  channel enable
- `dma_req`  in  1  request from endpoint; level, held until acknowledged
- `dma_ack`  out  1  one-cycle pulse per transferred word
- `wbm_adr`  out  32  master address; bits [1:0] are always 0
- `wbm_dout`  out  32  master write data
- `wbm_din`  in  32  master read data
- `wbm_we`  out  1  write strobe qualifier
- `wbm_stb`  out  1  cycle/strobe, also used as CYC
- `wbm_sel`  out  4  constant 4'hf
- `wbm_ack`  in  1  slave acknowledge
- `wbm_err`  in  1  slave error
- `busy`  out  1  FSM is in RD, WR or ACK
- `done`  out  1  one-cycle pulse when the remaining count reaches 0
- `err`  out  1  sticky bus-error flag
- `rem`  out  LEN_W  words remaining

## Operation
- Registers:
  - `mem_ptr[31:2]`
  - `buf_off[OFF_W-1:0]`
  - `rem`
  - `data_r[31:0]`
  - `dir`
- `cfg_we` loads:
  - `mem_ptr <= cfg_mem_adr[31:2]`
  - `buf_off <= 0`
  - `rem <= cfg_len`
  - `err <= 0`
- FSM states are IDLE, RD, WR, ACK, ERR.
- IDLE -> RD when `ch_en & dma_req & rem!=0 & !err`. Otherwise stay in IDLE; requests are ignored while `rem==0`.
- RD:
  - `wbm_stb=1`, `wbm_we=0`.
  - Address is the memory address if `dir=1`, otherwise the buffer address.
  - On `wbm_ack`: latch `data_r <= wbm_din`, go to WR.
- WR:
  - `wbm_stb=1`, `wbm_we=1`, `wbm_dout=data_r`.
  - Address is the buffer address if `dir=1`, otherwise the memory address.
  - On `wbm_ack`: go to ACK.
- ACK:
  - `dma_ack=1` for exactly this cycle.
  - `rem <= rem-1`.
  - `mem_ptr <= mem_ptr+1`, wrapping modulo 2^30.
  - `buf_off <= (buf_off == sz-1) ? 0 : buf_off+1`, where sz is `cfg_buf_sz` latched at config.
  - If `rem==1`, pulse `done`.
  - Next state is IDLE.
- Address rules:
  - Buffer address = `cfg_buf_base[31:2] + buf_off` (zero-extended, 30-bit sum, wraps), concatenated with 2'b00.
  - Memory address = `{mem_ptr, 2'b00}`.
- `wbm_err` in RD or WR: drop `wbm_stb`, set `err`, go to ERR, no `dma_ack`. Pointers and `rem` are left unchanged. ERR is left only by `cfg_we`, which goes to IDLE.
- `ch_en` falling in RD or WR: drop `wbm_stb` the next cycle and go to IDLE. No `dma_ack`, counters unchanged, and the word is retried on the next request. In ACK, `ch_en` is ignored; the ack completes.
- If `wbm_ack` and `wbm_err` are both high, `wbm_err` wins.
- `cfg_we` outside IDLE/ERR is ignored.

## Timing
- Reset values:
  - FSM in IDLE
  - `dma_ack=0`, `wbm_stb=0`, `wbm_we=0`
  - `wbm_adr=0`, `wbm_dout=0`
  - `busy=0`, `done=0`, `err=0`, `rem=0`
  - `mem_ptr=0`, `buf_off=0`
- Reset overrides any state, including mid bus cycle; `wbm_stb` is low the following cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Request seen in IDLE at edge t:
  - `wbm_stb` (read) is high from t+1.
  - With a zero-wait slave (`wbm_ack` in the same cycle), the write strobe is high at t+2.
  - `dma_ack` is high at t+3.
  - IDLE is reached at t+4; `dma_req` is sampled again there.
  - Minimum is 4 cycles per word; every slave wait state adds 1.
- `dma_req` is never sampled in ACK. The requester drops or holds it on the ack edge, so IDLE always sees the updated level.
- `done` coincides with the final `dma_ack`.

## Test plan
- Reset: assert `rst=0` for 2 cycles mid-RD -> all outputs 0 next cycle; `rem=0`.
- IN, 3 words:
  - Setup: `cfg_mem_adr=0x1000`, `cfg_buf_base=0x8000`, `cfg_buf_sz=8`, `dma_req` held high, zero-wait slave.
  - Reads expected at 0x1000/0x1004/0x1008, writes at 0x8000/0x8004/0x8008, same data.
  - `dma_ack` pulses 4 cycles apart; `done` with the third ack; later requests ignored.
- OUT ring wrap:
  - Setup: `cfg_buf_sz=2`, `cfg_len=3`, `cfg_buf_base=0x8000`.
  - Buffer reads expected at 0x8000, 0x8004, 0x8000; memory writes sequential.
- Wait states: slave inserts 2 waits on each access -> `dma_ack` 8 cycles after request; `wbm_adr`/`wbm_dout` stable while `wbm_stb` high.
- Error: `wbm_err` on the second word's WR -> `err=1`, no second `dma_ack`, `rem=cfg_len-1`, requests ignored; `cfg_we` clears `err`.
- Abort/zero length:
  - `ch_en` dropped during RD -> `wbm_stb` low next cycle, no ack, same address retried after re-enable.
  - `cfg_len=0` -> `dma_req` never acknowledged.
